// File: rtl/axis_egress_pkg.sv
// Shared types and constants for the buffered AXI-stream egress stage.
package axis_egress_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_DROP
  } wr_state_e;

  localparam int unsigned TUSER_ERR_BIT = 0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_egress_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module axis_egress_mem #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_egress_buf.sv
// Buffered AXI-stream egress: cut-through or store-and-forward with rewind-based frame drop.
// Optional frame statistics counters are enabled by defining AXIS_EGRESS_STATS_EN.
module axis_egress_buf
  import axis_egress_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PACKET_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [USER_WIDTH-1:0]    s_tuser,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [USER_WIDTH-1:0]    m_tuser,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     drop_pulse
`ifdef AXIS_EGRESS_STATS_EN
  ,
  output logic [31:0]              stat_frames_out,
  output logic [31:0]              stat_frames_dropped
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 1 + USER_WIDTH;
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, wr_ptr_q, wr_commit_q;
  wr_state_e     wr_state_q;
  logic          drop_pulse_q;
  logic          alive_q;

  logic [PW-1:0] fill;
  logic          full;
  logic          dropping;
  logic          oversize;
  logic          s_err;
  logic          s_fire;
  logic          wr_en;
  logic          m_fire;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign fill     = wr_ptr_q - rd_ptr_q;
  assign full     = (fill == DepthP);
  assign dropping = (wr_state_q == WR_DROP);
  assign s_err    = s_tuser[TUSER_ERR_BIT];

  // The in-flight frame alone fills the buffer: it can never commit, so discard it.
  assign oversize = (PACKET_MODE != 0) && (wr_state_q == WR_ACTIVE) && full &&
                    (wr_commit_q == rd_ptr_q);

  assign s_tready = alive_q && (dropping || !full);
  assign s_fire   = s_tvalid && s_tready;
  assign wr_en    = s_fire && !dropping;

  // Only committed entries are visible to the reader.
  assign m_tvalid = (rd_ptr_q != wr_commit_q);
  assign m_fire   = m_tvalid && m_tready;

  assign wr_entry = {s_tdata, s_tlast, s_tuser};
  assign {m_tdata, m_tlast, m_tuser} = rd_entry;

  assign occupancy  = fill;
  assign drop_pulse = drop_pulse_q;

  axis_egress_mem #(
    .Width(EW),
    .Depth(DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(wr_entry),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(rd_entry)
  );

  // Holds s_tready low through reset and releases it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
    end else if (m_fire) begin
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      wr_state_q   <= WR_IDLE;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (PACKET_MODE == 0) begin
        if (wr_en) begin
          wr_ptr_q    <= wr_ptr_q + 1'b1;
          wr_commit_q <= wr_ptr_q + 1'b1;
        end
      end else begin
        unique case (wr_state_q)
          WR_IDLE, WR_ACTIVE: begin
            if (oversize) begin
              wr_ptr_q     <= wr_commit_q;
              drop_pulse_q <= 1'b1;
              wr_state_q   <= WR_DROP;
            end else if (wr_en) begin
              if (!s_tlast) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                wr_state_q <= WR_ACTIVE;
              end else if (s_err) begin
                wr_ptr_q     <= wr_commit_q;
                drop_pulse_q <= 1'b1;
                wr_state_q   <= WR_IDLE;
              end else begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                wr_commit_q <= wr_ptr_q + 1'b1;
                wr_state_q  <= WR_IDLE;
              end
            end
          end
          WR_DROP: begin
            if (s_fire && s_tlast) begin
              wr_state_q <= WR_IDLE;
            end
          end
          default: wr_state_q <= WR_IDLE;
        endcase
      end
    end
  end

`ifdef AXIS_EGRESS_STATS_EN
  logic [31:0] frames_out_q, frames_drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_out_q  <= '0;
      frames_drop_q <= '0;
    end else begin
      if (m_fire && m_tlast) begin
        frames_out_q <= sat_inc32(frames_out_q);
      end
      if (drop_pulse_q) begin
        frames_drop_q <= sat_inc32(frames_drop_q);
      end
    end
  end

  assign stat_frames_out     = frames_out_q;
  assign stat_frames_dropped = frames_drop_q;
`endif

endmodule

// File: tb/tb_axis_egress_buf.sv
// Bench for axis_egress_buf: three instances (cut-through/16, packet/16, packet/4) checked
// every cycle against a queue-level model, plus directed literal expectations.
module tb_axis_egress_buf;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [63:0] s_tdata  [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic        s_tlast  [3];
  logic [0:0]  s_tuser  [3];
  logic [63:0] m_tdata  [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        m_tlast  [3];
  logic [0:0]  m_tuser  [3];
  logic        drop     [3];
  logic [4:0]  occ0, occ1;
  logic [2:0]  occ2;
`ifdef AXIS_EGRESS_STATS_EN
  logic [31:0] st_out  [3];
  logic [31:0] st_drop [3];
`endif

  // Model state: committed-unread beats, in-progress frame, expected pulses.
  beat_t exp_mem [3][64];
  int    exp_hd [3];
  int    exp_tl [3];
  beat_t frm [3][64];
  int    frm_n [3];
  bit    drop_mode [3];
  bit    exp_drop [3];
  bit    exp_alive = 1'b0;
  int    exp_fo [3];
  int    exp_fd [3];

  // Observation log for literal checks.
  beat_t out_log [3][64];
  int    out_cyc [3][64];
  int    out_n [3];
  int    drop_seen [3];
  int    peak [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_egress_buf #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEPTH(16), .PACKET_MODE(0)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
    .s_tlast(s_tlast[0]), .s_tuser(s_tuser[0]),
    .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
    .m_tlast(m_tlast[0]), .m_tuser(m_tuser[0]),
    .occupancy(occ0), .drop_pulse(drop[0])
`ifdef AXIS_EGRESS_STATS_EN
    , .stat_frames_out(st_out[0]), .stat_frames_dropped(st_drop[0])
`endif
  );

  axis_egress_buf #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEPTH(16), .PACKET_MODE(1)) u_sf16 (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
    .s_tlast(s_tlast[1]), .s_tuser(s_tuser[1]),
    .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
    .m_tlast(m_tlast[1]), .m_tuser(m_tuser[1]),
    .occupancy(occ1), .drop_pulse(drop[1])
`ifdef AXIS_EGRESS_STATS_EN
    , .stat_frames_out(st_out[1]), .stat_frames_dropped(st_drop[1])
`endif
  );

  axis_egress_buf #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEPTH(4), .PACKET_MODE(1)) u_sf4 (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata[2]), .s_tvalid(s_tvalid[2]), .s_tready(s_tready[2]),
    .s_tlast(s_tlast[2]), .s_tuser(s_tuser[2]),
    .m_tdata(m_tdata[2]), .m_tvalid(m_tvalid[2]), .m_tready(m_tready[2]),
    .m_tlast(m_tlast[2]), .m_tuser(m_tuser[2]),
    .occupancy(occ2), .drop_pulse(drop[2])
`ifdef AXIS_EGRESS_STATS_EN
    , .stat_frames_out(st_out[2]), .stat_frames_dropped(st_drop[2])
`endif
  );

  function automatic int get_occ(input int i);
    case (i)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  function automatic int depth_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  task automatic chk(input int i, input string nm, input logic [63:0] act,
                     input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", i, nm, act, exp_v, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int    oc;
      int    ocx;
      bit    rdy_x;
      bit    vld_x;
      bit    mf;
      bit    sf;
      beat_t fr;
      oc = get_occ(i);
      if (!rst_n) begin
        chk(i, "rst_s_tready", s_tready[i], 0);
        chk(i, "rst_m_tvalid", m_tvalid[i], 0);
        chk(i, "rst_occupancy", oc, 0);
        chk(i, "rst_drop_pulse", drop[i], 0);
`ifdef AXIS_EGRESS_STATS_EN
        chk(i, "rst_stat_out", st_out[i], 0);
        chk(i, "rst_stat_drop", st_drop[i], 0);
        exp_fo[i] = 0;
        exp_fd[i] = 0;
`endif
        exp_hd[i] = 0;
        exp_tl[i] = 0;
        frm_n[i] = 0;
        drop_mode[i] = 1'b0;
        exp_drop[i] = 1'b0;
      end else begin
        ocx   = (exp_tl[i] - exp_hd[i]) + frm_n[i];
        rdy_x = exp_alive && (drop_mode[i] || ocx < depth_of(i));
        vld_x = (exp_tl[i] != exp_hd[i]);
        if (oc > peak[i]) peak[i] = oc;
        chk(i, "occupancy", oc, ocx);
        chk(i, "s_tready", s_tready[i], rdy_x);
        chk(i, "m_tvalid", m_tvalid[i], vld_x);
        chk(i, "drop_pulse", drop[i], exp_drop[i]);
        if (vld_x) begin
          fr = exp_mem[i][exp_hd[i] % 64];
          chk(i, "m_tdata", m_tdata[i], fr.d);
          chk(i, "m_tlast", m_tlast[i], fr.l);
          chk(i, "m_tuser", m_tuser[i], fr.u);
        end
`ifdef AXIS_EGRESS_STATS_EN
        chk(i, "stat_frames_out", st_out[i], exp_fo[i]);
        chk(i, "stat_frames_dropped", st_drop[i], exp_fd[i]);
`endif
        if (drop[i]) drop_seen[i]++;
        if (exp_drop[i]) exp_fd[i]++;
        exp_drop[i] = 1'b0;
        mf = vld_x && m_tready[i];
        sf = s_tvalid[i] && rdy_x;
        if (mf) begin
          out_log[i][out_n[i] % 64] = {m_tdata[i], m_tlast[i], m_tuser[i]};
          out_cyc[i][out_n[i] % 64] = cyc;
          out_n[i]++;
          if (exp_mem[i][exp_hd[i] % 64].l) exp_fo[i]++;
          exp_hd[i]++;
        end
        fr = {s_tdata[i], s_tlast[i], s_tuser[i]};
        if (i == 0) begin
          if (sf) begin
            exp_mem[i][exp_tl[i] % 64] = fr;
            exp_tl[i]++;
          end
        end else if (!drop_mode[i] && frm_n[i] == depth_of(i) && !vld_x) begin
          frm_n[i] = 0;
          drop_mode[i] = 1'b1;
          exp_drop[i] = 1'b1;
        end else if (sf) begin
          if (drop_mode[i]) begin
            if (fr.l) drop_mode[i] = 1'b0;
          end else begin
            frm[i][frm_n[i]] = fr;
            frm_n[i]++;
            if (fr.l && fr.u) begin
              frm_n[i] = 0;
              exp_drop[i] = 1'b1;
            end else if (fr.l) begin
              for (int k = 0; k < frm_n[i]; k++) begin
                exp_mem[i][exp_tl[i] % 64] = frm[i][k];
                exp_tl[i]++;
              end
              frm_n[i] = 0;
            end
          end
        end
      end
    end
    exp_alive = rst_n;
  end

  task automatic send(input int i, input logic [63:0] d, input bit l, input bit u,
                      output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    s_tdata[i]  = d;
    s_tlast[i]  = l;
    s_tuser[i]  = u;
    s_tvalid[i] = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (s_tready[i]) begin
        @(posedge clk);
        #1;
        ok  = 1'b1;
        acc = cyc;
      end
    end
    s_tvalid[i] = 1'b0;
    chk(i, "send_accepted", ok, 1);
  endtask

  task automatic send_frame(input int i, input logic [63:0] base, input int n, input bit err,
                            input bit last_on, output int last_acc);
    int a;
    for (int k = 0; k < n; k++) begin
      send(i, base + 64'(k), last_on && (k == n - 1), err && (k == n - 1), a);
    end
    last_acc = a;
  endtask

  task automatic wait_out(input int i, input int n);
    for (int k = 0; k < 400 && out_n[i] < n; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk(i, "out_beat_count", out_n[i], n);
  endtask

  int base;
  int ds;
  int a0, a1, a2, la;
  beat_t b;

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tuser[i] = '0;
      m_tready[i] = 1'b0;
      exp_hd[i] = 0; exp_tl[i] = 0; frm_n[i] = 0; drop_mode[i] = 1'b0; exp_drop[i] = 1'b0;
      exp_fo[i] = 0; exp_fd[i] = 0; out_n[i] = 0; drop_seen[i] = 0; peak[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(0, "lit_rst_s_tready", s_tready[0], 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(0, "lit_ready_after_release", s_tready[0], 1);

    // Cut-through: each beat visible the cycle after acceptance.
    m_tready[0] = 1'b1;
    peak[0] = 0;
    base = out_n[0];
    send(0, 64'hA0, 1'b0, 1'b0, a0);
    send(0, 64'hA1, 1'b0, 1'b0, a1);
    send(0, 64'hA2, 1'b1, 1'b0, a2);
    wait_out(0, base + 3);
    b = out_log[0][base % 64];       chk(0, "ct_d0", b.d, 64'hA0); chk(0, "ct_l0", b.l, 0);
    b = out_log[0][(base + 1) % 64]; chk(0, "ct_d1", b.d, 64'hA1); chk(0, "ct_l1", b.l, 0);
    b = out_log[0][(base + 2) % 64]; chk(0, "ct_d2", b.d, 64'hA2); chk(0, "ct_l2", b.l, 1);
    chk(0, "ct_lat0", out_cyc[0][base % 64], a0);
    chk(0, "ct_lat1", out_cyc[0][(base + 1) % 64], a1);
    chk(0, "ct_lat2", out_cyc[0][(base + 2) % 64], a2);
    chk(0, "ct_peak_occ", peak[0], 1);

    // Backpressure: 20 beats offered into 16 entries.
    m_tready[0] = 1'b0;
    base = out_n[0];
    fork
      send_frame(0, 64'h100, 20, 1'b0, 1'b1, la);
      begin
        repeat (25) @(posedge clk);
        #1;
        chk(0, "bp_occ_full", occ0, 16);
        chk(0, "bp_s_tready_low", s_tready[0], 0);
        m_tready[0] = 1'b1;
      end
    join
    wait_out(0, base + 20);
    for (int k = 0; k < 20; k++) begin
      b = out_log[0][(base + k) % 64];
      chk(0, "bp_order_data", b.d, 64'h100 + 64'(k));
      chk(0, "bp_order_last", b.l, (k == 19) ? 1 : 0);
    end

    // Store-and-forward: nothing leaves before tlast, then back-to-back.
    m_tready[1] = 1'b1;
    base = out_n[1];
    send_frame(1, 64'hC0, 4, 1'b0, 1'b1, la);
    wait_out(1, base + 4);
    for (int k = 0; k < 4; k++) begin
      b = out_log[1][(base + k) % 64];
      chk(1, "sf_data", b.d, 64'hC0 + 64'(k));
      chk(1, "sf_cycle", out_cyc[1][(base + k) % 64], la + k);
    end

    // Good, errored, good: only good frames leave, one drop, occupancy restored.
    m_tready[1] = 1'b0;
    base = out_n[1];
    ds = drop_seen[1];
    send_frame(1, 64'hD0, 3, 1'b0, 1'b1, la);
    repeat (2) @(posedge clk);
    #1;
    chk(1, "err_occ_before", occ1, 3);
    send_frame(1, 64'hE0, 3, 1'b1, 1'b1, la);
    repeat (3) @(posedge clk);
    #1;
    chk(1, "err_occ_after", occ1, 3);
    chk(1, "err_drop_count", drop_seen[1] - ds, 1);
    send_frame(1, 64'hF0, 3, 1'b0, 1'b1, la);
    repeat (2) @(posedge clk);
    #1;
    chk(1, "err_occ_two_frames", occ1, 6);
    m_tready[1] = 1'b1;
    wait_out(1, base + 6);
    for (int k = 0; k < 6; k++) begin
      b = out_log[1][(base + k) % 64];
      chk(1, "err_data", b.d, (k < 3) ? 64'hD0 + 64'(k) : 64'hF0 + 64'(k - 3));
      chk(1, "err_last", b.l, (k == 2 || k == 5) ? 1 : 0);
    end
    chk(1, "err_drop_total", drop_seen[1] - ds, 1);

    // Oversize frame on a 4-entry buffer is dropped; next frame intact.
    m_tready[2] = 1'b1;
    base = out_n[2];
    ds = drop_seen[2];
    send_frame(2, 64'h300, 6, 1'b0, 1'b1, la);
    send_frame(2, 64'h400, 2, 1'b0, 1'b1, la);
    wait_out(2, base + 2);
    b = out_log[2][base % 64];       chk(2, "ovs_d0", b.d, 64'h400); chk(2, "ovs_l0", b.l, 0);
    b = out_log[2][(base + 1) % 64]; chk(2, "ovs_d1", b.d, 64'h401); chk(2, "ovs_l1", b.l, 1);
    chk(2, "ovs_drop_count", drop_seen[2] - ds, 1);
    chk(2, "ovs_occ_empty", occ2, 0);

    // Reset mid-frame with 5 entries stored.
    m_tready[0] = 1'b0;
    m_tready[1] = 1'b0;
    send_frame(0, 64'h500, 5, 1'b0, 1'b0, la);
    send_frame(1, 64'h600, 5, 1'b0, 1'b0, la);
    repeat (2) @(posedge clk);
    #1;
    chk(0, "mid_occ_before", occ0, 5);
    chk(0, "mid_valid_before", m_tvalid[0], 1);
    chk(1, "mid_occ_before", occ1, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk(0, "mid_rst_valid", m_tvalid[0], 0);
    chk(0, "mid_rst_occ", occ0, 0);
    chk(1, "mid_rst_valid", m_tvalid[1], 0);
    chk(1, "mid_rst_occ", occ1, 0);
`ifdef AXIS_EGRESS_STATS_EN
    chk(1, "mid_rst_stat_out", st_out[1], 0);
    chk(1, "mid_rst_stat_drop", st_drop[1], 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Recovery after reset.
    m_tready[0] = 1'b1;
    base = out_n[0];
    send(0, 64'h7A, 1'b1, 1'b0, a0);
    wait_out(0, base + 1);
    b = out_log[0][base % 64];
    chk(0, "recover_data", b.d, 64'h7A);
    chk(0, "recover_last", b.l, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_egress_buf.md
Name: axis_egress_buf

Overview:
- Buffered AXI-stream egress boundary; replaces pure-wire egress where the external sink can stall or must never see partial or errored frames.
- DEPTH-entry FIFO between the internal stream (s_*) and the external port (m_*).
- Two modes: cut-through, or store-and-forward with rewind-based frame drop.
- Sits at the last stage of the pipeline, directly before the MAC/PHY-side stream.

Parameters:
- DATA_WIDTH, 64, tdata width in bits.
- USER_WIDTH, 1, tuser width; bit 0 is the frame-error flag.
- DEPTH, 16, FIFO entries; power of two, ≥4.
- PACKET_MODE, 1, 0 = cut-through, 1 = store-and-forward with error/oversize drop.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  DATA_WIDTH  internal stream data.
- s_tvalid  in  1  internal valid.
- s_tready  out  1  internal ready.
- s_tlast  in  1  internal end of frame.
- s_tuser  in  USER_WIDTH  internal sideband; [0] = error.
- m_tdata  out  DATA_WIDTH  external data.
- m_tvalid  out  1  external valid.
- m_tready  in  1  external ready.
- m_tlast  out  1  external end of frame.
- m_tuser  out  USER_WIDTH  external sideband.
- occupancy  out  $clog2(DEPTH)+1  entries currently written, including uncommitted ones.
- drop_pulse  out  1  one-cycle pulse per dropped frame.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - all pointers 0; occupancy 0; write FSM in WR_IDLE.
  - s_tready 0 while rst_n is low, 1 from the first cycle after release.
  - m_tvalid 0, drop_pulse 0. m_tdata/m_tlast/m_tuser are don't-care while m_tvalid is 0.
- Storage: each entry holds {tdata, tlast, tuser}.
- Pointers: rd_ptr, wr_ptr (speculative), wr_commit. All are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. full = (wr_ptr − rd_ptr == DEPTH).
- Handshake:
  - s-beat accepted when s_tvalid && s_tready.
  - m-beat consumed when m_tvalid && m_tready.
  - m_tvalid/m_tdata must stay stable while m_tvalid && !m_tready.
- Cut-through (PACKET_MODE=0):
  - wr_commit tracks wr_ptr every beat.
  - s_tready = !full.
  - Beat accepted in cycle N appears on m_* in cycle N+1.
  - tuser passed through unchanged; no drops.
- Store-and-forward (PACKET_MODE=1), write FSM:
  - WR_IDLE: first accepted beat → WR_ACTIVE; a single-beat frame (tlast) is handled as below.
  - WR_ACTIVE, accepted beat with tlast && !tuser[0]: wr_commit ← wr_ptr+1; → WR_IDLE.
  - WR_ACTIVE, accepted beat with tlast && tuser[0]: wr_ptr ← wr_commit (rewind); drop_pulse; → WR_IDLE.
  - Oversize: (wr_ptr − rd_ptr == DEPTH) with no tlast yet and wr_commit == rd_ptr: rewind, drop_pulse, → WR_DROP.
  - WR_DROP: s_tready = 1; beats are discarded; tlast → WR_IDLE.
  - s_tready = !full in WR_IDLE/WR_ACTIVE. When full and committed frames exist, stall until the reader drains them.
  - Read side serves only entries below wr_commit.
  - A frame whose tlast beat is accepted in cycle N has its first beat on m_* in cycle N+1.
- Simultaneous read and write in the same cycle: occupancy is unchanged; both pointers advance.
- Rewind coincident with a read: rd_ptr still advances, and the read entry is always committed.
- occupancy = wr_ptr − rd_ptr, updated in the cycle after each event.
- Reset asserted mid-frame: all state clears immediately; a partial frame is lost without drop_pulse.

Optional Feature:
- Macro: AXIS_EGRESS_STATS_EN.
- When defined, adds outputs stat_frames_out[31:0] (counts m-beats with tlast) and stat_frames_dropped[31:0] (counts drop_pulse).
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_egress_pkg holds:
  - the write FSM typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DROP};
  - the error-bit index constant TUSER_ERR_BIT = 0.
- Sub-module axis_egress_mem: simple dual-port register array, DEPTH × (DATA_WIDTH+1+USER_WIDTH), synchronous write, combinational read. The top level keeps pointers, FSM and flags.

Test Plan:
- Cut-through, m_tready=1, 3-beat frame 0xA0..0xA2: m_* shows each beat one cycle after it is accepted; tlast on 0xA2; occupancy peaks at 1.
- Backpressure, DEPTH=16, m_tready=0, 20 beats offered: s_tready drops after 16 accepts and occupancy=16. Release m_tready: all 20 beats exit in order with no duplicates.
- PACKET_MODE=1, 4-beat frame: m_tvalid stays 0 until the cycle after tlast is accepted, then 4 back-to-back beats follow.
- PACKET_MODE=1: good frame (3 beats), then error frame (tuser[0]=1 on tlast), then good frame. Only the two good frames appear on m_*; drop_pulse asserts once; occupancy returns to its pre-error value.
- PACKET_MODE=1, DEPTH=4, 6-beat frame with an empty FIFO: drop_pulse fires; the remaining beats are accepted and discarded; the next 2-beat frame passes intact.
- Assert rst_n low mid-frame with 5 entries stored: next cycle m_tvalid=0 and occupancy=0; stat counters are 0 when AXIS_EGRESS_STATS_EN is defined.
